// File: rtl/pulse_cdc_pkg.sv
// rtl/pulse_cdc_pkg.sv - shared FSM encoding and synchronizer depth for the pulse CDC blocks
package pulse_cdc_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } pcdc_state_e;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop single-bit synchronizer with async active-low reset
module bit_sync
    import pulse_cdc_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_src_pacer.sv
// rtl/pulse_src_pacer.sv - source-side event pacer for the toggle pulse synchronizer
// Optional ack timeout recovery is built when PULSE_SRC_PACER_TIMEOUT_EN is defined.
module pulse_src_pacer
    import pulse_cdc_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             evt_i,
    input  logic             ack_tgl_i,
    input  logic             ovf_clr_i,
    output logic             puls_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pend_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pulse_src_pacer: SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("pulse_src_pacer: TIMEOUT_CYC must be at least 2");
    end

    pcdc_state_e      state_q;
    logic             req_tgl_q;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic             ack_s;
    logic             issue;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (ack_tgl_i),
        .q_o    (ack_s)
    );

    assign issue = (state_q == SEND);

    // Saturating counter: an event arriving at max with nothing issued is dropped and flagged.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (evt_i && !issue) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!evt_i && issue) begin
            pend_d = pend_q - 1'b1;
        end
        ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef PULSE_SRC_PACER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] wait_q;
    logic          err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            req_tgl_q <= 1'b0;
`ifdef PULSE_SRC_PACER_TIMEOUT_EN
            wait_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef PULSE_SRC_PACER_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pend_q != '0) begin
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    state_q   <= WAIT_ACK;
                    req_tgl_q <= ~req_tgl_q;
`ifdef PULSE_SRC_PACER_TIMEOUT_EN
                    wait_q    <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (ack_s == req_tgl_q) begin
                        state_q <= IDLE;
`ifdef PULSE_SRC_PACER_TIMEOUT_EN
                    // Give up on a lost ack: realign the toggle and count the event as issued.
                    end else if (wait_q == TW'(TIMEOUT_CYC - 1)) begin
                        err_q     <= 1'b1;
                        req_tgl_q <= ack_s;
                        state_q   <= IDLE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign puls_o = (state_q == SEND);
    assign busy_o = (state_q != IDLE);
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

endmodule
